// File: rtl/parallel_to_serial.sv
// parallel_to_serial: double-buffered word serializer, LSB first.
// A holding register queues the next word while the current one shifts out.
module parallel_to_serial #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             parallel_valid,
   input  logic [width-1:0] parallel_data,
   output logic             parallel_ready,
   input  logic             serial_ready,
   output logic             serial_valid,
   output logic             serial_data
);
   localparam int CW = $clog2(width);
   localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

   logic [width-1:0] shift_q, shift_d;
   logic [width-1:0] hold_q, hold_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             hold_full_q, hold_full_d;
   logic             acc, bit_xfer, last;

   assign serial_valid   = active_q;
   assign serial_data    = active_q & shift_q[0];
   assign parallel_ready = ~hold_full_q & ~rst;

   assign acc      = parallel_valid & parallel_ready;
   assign bit_xfer = active_q & serial_ready;
   assign last     = bit_xfer & (cnt_q == LAST_CNT);

   always_comb begin
      shift_d     = shift_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      active_d    = active_q;
      hold_full_d = hold_full_q;
      if (last) begin
         cnt_d = '0;
         if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
         end else if (acc) begin
            shift_d = parallel_data;
         end else begin
            shift_d  = '0;
            active_d = 1'b0;
         end
      end else begin
         if (bit_xfer) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
         end
         // A word arriving mid-shift parks in the buffer; otherwise it starts now.
         if (acc) begin
            if (active_q) begin
               hold_d      = parallel_data;
               hold_full_d = 1'b1;
            end else begin
               shift_d  = parallel_data;
               cnt_d    = '0;
               active_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q     <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         active_q    <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         hold_full_q <= hold_full_d;
      end
   end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: random words checked against a
// word-level reference that reassembles the serial stream LSB first.
module tb_parallel_to_serial;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         parallel_valid = 1'b0;
   logic [W-1:0] parallel_data = '0;
   logic         parallel_ready;
   logic         serial_ready = 1'b1;
   logic         serial_valid;
   logic         serial_data;

   logic sr_rand = 1'b0;
   logic sr_fixed = 1'b1;

   int vectors = 0;
   int miscompares = 0;

   bit   bq[$];
   int   cq[$];
   int   cyc = 0;
   int   stall_bad = 0;
   logic prev_stall = 1'b0;
   logic prev_data = 1'b0;

   parallel_to_serial #(.width(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .parallel_valid(parallel_valid),
      .parallel_data (parallel_data),
      .parallel_ready(parallel_ready),
      .serial_ready  (serial_ready),
      .serial_valid  (serial_valid),
      .serial_data   (serial_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      serial_ready = sr_rand ? 1'($urandom_range(0, 1)) : sr_fixed;
   end

   // Serial-side observer: records every transferred bit and watches stalls.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && serial_valid && serial_data !== prev_data)
            stall_bad = stall_bad + 1;
         if (serial_valid && serial_ready) begin
            bq.push_back(serial_data);
            cq.push_back(cyc);
         end
         prev_stall = serial_valid & ~serial_ready;
         prev_data  = serial_data;
      end
   end

   function automatic logic [W-1:0] word_at(input int idx);
      logic [W-1:0] w;
      w = '0;
      for (int b = 0; b < W; b++) w[b] = bq[idx + b];
      return w;
   endfunction

   task automatic push(input logic [W-1:0] d, output int waits);
      parallel_valid = 1'b1;
      parallel_data  = d;
      waits = 0;
      @(negedge clk);
      while (!parallel_ready && waits < 300) begin
         waits++;
         @(negedge clk);
      end
      if (!parallel_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL push_timeout: ready=%b required 1", parallel_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      parallel_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input int target);
      int k;
      k = 0;
      while (bq.size() < target && k < 5000) begin
         @(posedge clk);
         k++;
      end
      #1;
   endtask

   task automatic test_reset;
      int w;
      repeat (2) @(negedge clk);
      vectors++;
      if ({serial_valid, serial_data, parallel_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_hold: v/d/rdy=%b required 000",
                  {serial_valid, serial_data, parallel_ready});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({serial_valid, parallel_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_release: v/rdy=%b required 01",
                  {serial_valid, parallel_ready});
      end
      @(posedge clk); #1;
      push(8'hAA, w);
      push(8'h55, w);
      @(posedge clk); #1;
      parallel_valid = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if ({serial_valid, serial_data, parallel_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_async: v/d/rdy=%b required 000",
                  {serial_valid, serial_data, parallel_ready});
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({serial_valid, parallel_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_mid_release: v/rdy=%b required 01",
                  {serial_valid, parallel_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      logic [W-1:0] v;
      int w;
      v = 8'hA5;
      push(v, w);
      parallel_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         vectors++;
         if ({serial_valid, serial_data} !== {1'b1, v[i]}) begin
            miscompares++;
            $display("FAIL single_bit%0d: v/d=%b required 1%b", i,
                     {serial_valid, serial_data}, v[i]);
         end
      end
      @(negedge clk);
      vectors++;
      if ({serial_valid, serial_data} !== 2'b00) begin
         miscompares++;
         $display("FAIL single_end: v/d=%b required 00",
                  {serial_valid, serial_data});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int base, w0, w1, w2;
      logic [23:0] got;
      base = bq.size();
      push(8'h01, w0);
      push(8'h80, w1);
      push(8'hFF, w2);
      parallel_valid = 1'b0;
      drain(base + 24);
      idle(3);
      vectors++;
      if (bq.size() - base !== 24) begin
         miscompares++;
         $display("FAIL b2b_count: bits=%0d required 24", bq.size() - base);
      end else begin
         for (int i = 0; i < 24; i++) got[i] = bq[base + i];
         vectors++;
         if (got !== 24'hFF8001) begin
            miscompares++;
            $display("FAIL b2b_bits: got=%h required ff8001", got);
         end
         vectors++;
         if (cq[base + 23] - cq[base] !== 23) begin
            miscompares++;
            $display("FAIL b2b_contig: span=%0d required 23",
                     cq[base + 23] - cq[base]);
         end
      end
      vectors++;
      if (w2 !== 7) begin
         miscompares++;
         $display("FAIL b2b_full_stall: ready-low cycles=%0d required 7", w2);
      end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] exp_q[$];
      logic [W-1:0] d;
      int base, w, s0;
      base = bq.size();
      s0 = stall_bad;
      sr_rand = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d = W'($urandom);
         exp_q.push_back(d);
         push(d, w);
      end
      parallel_valid = 1'b0;
      drain(base + 20 * W);
      sr_rand = 1'b0;
      idle(3);
      vectors++;
      if (bq.size() - base !== 20 * W) begin
         miscompares++;
         $display("FAIL bp_count: bits=%0d required %0d",
                  bq.size() - base, 20 * W);
      end else begin
         for (int i = 0; i < 20; i++) begin
            vectors++;
            if (word_at(base + i * W) !== exp_q[i]) begin
               miscompares++;
               $display("FAIL bp_word%0d: got=%h required %h", i,
                        word_at(base + i * W), exp_q[i]);
            end
         end
      end
      vectors++;
      if (stall_bad - s0 !== 0) begin
         miscompares++;
         $display("FAIL bp_stall_hold: changes=%0d required 0", stall_bad - s0);
      end
   endtask

   task automatic test_reset_mid;
      int base, base2, w;
      base = bq.size();
      push(8'h3C, w);
      push(8'hC3, w);
      @(posedge clk);
      @(posedge clk);
      #1;
      parallel_valid = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if ({serial_valid, serial_data} !== 2'b00) begin
         miscompares++;
         $display("FAIL rstmid_drop: v/d=%b required 00",
                  {serial_valid, serial_data});
      end
      vectors++;
      if (bq.size() - base !== 3) begin
         miscompares++;
         $display("FAIL rstmid_bits_before: bits=%0d required 3",
                  bq.size() - base);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      base2 = bq.size();
      idle(5);
      vectors++;
      if (bq.size() - base2 !== 0) begin
         miscompares++;
         $display("FAIL rstmid_leftover: bits=%0d required 0",
                  bq.size() - base2);
      end
      push(8'h5A, w);
      parallel_valid = 1'b0;
      drain(base2 + W);
      idle(4);
      vectors++;
      if (bq.size() - base2 !== W) begin
         miscompares++;
         $display("FAIL rstmid_count: bits=%0d required %0d",
                  bq.size() - base2, W);
      end else begin
         vectors++;
         if (word_at(base2) !== 8'h5A) begin
            miscompares++;
            $display("FAIL rstmid_word: got=%h required 5a", word_at(base2));
         end
      end
   endtask

   task automatic test_loopback;
      logic [W-1:0] exp_q[$];
      logic [W-1:0] d;
      int base, w;
      base = bq.size();
      for (int i = 0; i < 200; i++) begin
         d = W'($urandom);
         exp_q.push_back(d);
         push(d, w);
      end
      parallel_valid = 1'b0;
      drain(base + 200 * W);
      idle(4);
      vectors++;
      if (bq.size() - base !== 200 * W) begin
         miscompares++;
         $display("FAIL loop_count: bits=%0d required %0d",
                  bq.size() - base, 200 * W);
      end else begin
         for (int i = 0; i < 200; i++) begin
            vectors++;
            if (word_at(base + i * W) !== exp_q[i]) begin
               miscompares++;
               $display("FAIL loop_word%0d: got=%h required %h", i,
                        word_at(base + i * W), exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Double-buffered serializer. It accepts `width`-bit words over a valid/ready handshake and emits them one bit per cycle, LSB first, on a serial valid/ready interface. It sits directly upstream of `serial_to_parallel`: the first bit sent lands in bit 0 of the deserialized word, so a loopback reproduces each word unchanged. The holding buffer lets a new word be accepted while the current one shifts out, so words stream back-to-back with no idle cycle between them.

## Interface
- `width`, default 8: word size in bits; legal range width >= 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `parallel_valid`  in  1: upstream word present.
- `parallel_data`  in  width: upstream word.
- `parallel_ready`  out  1: block can take a word; a word transfers on a rising edge where valid & ready.
- `serial_ready`  in  1: downstream takes the current bit.
- `serial_valid`  out  1: a bit is being presented.
- `serial_data`  out  1: the current bit; forced to 0 whenever serial_valid = 0.

## Operation
- State:
  - shifter: `shift_reg[width-1:0]`, `bit_cnt` ($clog2(width) bits) and `active`.
  - holding buffer: `hold_reg[width-1:0]` and `hold_full`.
- Combinational outputs:
  - `serial_valid = active`
  - `serial_data = active & shift_reg[0]`
  - `parallel_ready = ~hold_full & ~rst`
- Events in a cycle:
  - `acc = parallel_valid & parallel_ready`
  - `bit = serial_valid & serial_ready`
  - `last = bit & (bit_cnt == width-1)`
- On a bit transfer that is not the last bit: shift_reg shifts right by 1 (zero fill) and bit_cnt increments.
- On a last-bit transfer:
  - hold_full = 1: load hold_reg into shift_reg, set bit_cnt = 0, keep active = 1, clear hold_full.
  - hold_full = 0 and acc: load parallel_data into shift_reg, set bit_cnt = 0, keep active = 1. This is the no-bubble path.
  - hold_full = 0 and no acc: clear active, bit_cnt and shift_reg.
- acc while active = 0: load parallel_data into shift_reg, set bit_cnt = 0, set active = 1.
- acc while active = 1 and not last: write parallel_data into hold_reg and set hold_full.
- No transfer in a cycle: all state holds. serial_data stays stable while serial_valid & ~serial_ready, across any number of stall cycles.
- Word order is strictly FIFO. The block never drops or duplicates a word.

## Timing
- While rst is high and after it is released: active = 0, hold_full = 0, shift_reg = 0, bit_cnt = 0.
  - serial_valid = 0, serial_data = 0.
  - parallel_ready = 0 while rst is high, 1 from the first cycle after release.
- Latency: a word accepted at edge N drives its bit 0 in the cycle after edge N (serial_valid rises right after edge N).
- Throughput: with serial_ready held at 1, one word per width cycles. serial_valid stays high continuously while upstream keeps the buffer fed.
- parallel_ready drops in the cycle after a word is written into the holding buffer. It rises again in the cycle after the buffer moves into the shifter.
- parallel_ready does not depend combinationally on serial_ready or parallel_valid.
- Reset mid-word: rst takes effect asynchronously. The in-flight word and any buffered word are discarded, and serial_valid falls without waiting for a clock edge.
- Simultaneous last-bit transfer and acc with the buffer empty: the new word starts the very next cycle, with no bubble.

## Test plan
- Reset: assert rst mid-stream, then release. Required: serial_valid = 0, serial_data = 0, parallel_ready = 0 during reset and 1 on the first cycle after release.
- Single word 8'hA5 with serial_ready = 1. Required: serial_valid is high for exactly 8 cycles starting the cycle after accept, and serial_data reads 1,0,1,0,0,1,0,1; then serial_valid = 0.
- Back-to-back words 8'h01, 8'h80, 8'hFF with parallel_valid held high. Required:
  - 24 contiguous serial_valid cycles with bits 10000000 00000001 11111111;
  - parallel_ready = 0 while the buffer is full.
- Backpressure: serial_ready driven pseudo-randomly (about 50%) over 20 words. Required: the bit sequence is identical to the unstalled run, and serial_data holds steady through every stall.
- Reset mid-word: 8'h3C accepted and 8'hC3 buffered, rst asserted after 3 bits. Required:
  - serial_valid drops immediately;
  - after release, no bits of 8'h3C or 8'hC3 appear;
  - a new word 8'h5A is serialized correctly.
- Loopback into `serial_to_parallel` (width 8, serial_ready tied to 1) with 200 random words. Required: each parallel_valid pulse carries the next word in order, with no loss or duplication.
